mips_ctl_alu_dmem: RTL and testbench

- Combined decode/execute/memory slice for the 5-stage MIPS pipeline. It holds three independent parts:
  - combinational control decoder (ID stage), driven from the IF/ID instruction;
  - combinational 32-bit ALU (EXE stage), driven from ID/EXE outputs;
  - clocked, word-addressed data memory (MEM stage), driven from EXE/MEM outputs.
- Each part has its own port group, so the pipeline registers connect to them without extra glue.

---
 rtl/mips_ctl_alu_dmem_pkg.sv | 51 +++++
 rtl/mips_ctl_alu_dmem_dmem_array.sv | 41 ++++
 rtl/mips_ctl_alu_dmem.sv | 110 +++++++++++
 tb/tb_mips_ctl_alu_dmem.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctl_alu_dmem_pkg.sv
// Shared decode constants, ALU op encoding and data-memory preload image.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_ctl_alu_dmem_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;

    typedef enum logic [1:0] {
        ALUC_ADD = 2'b00,
        ALUC_SUB = 2'b01,
        ALUC_AND = 2'b10,
        ALUC_OR  = 2'b11
    } aluc_e;

    typedef struct packed {
        logic  wreg;
        logic  m2reg;
        logic  wmem;
        aluc_e aluc;
        logic  aluimm;
        logic  regrt;
    } ctl_t;

    // Words 0..9 carry a recognisable pattern; everything above is zero.
    function automatic logic [31:0] preload_word(input int unsigned idx);
        logic [31:0] w;
        case (idx)
            0:       w = 32'hA000_00AA;
            1:       w = 32'h1000_0011;
            2:       w = 32'h2000_0022;
            3:       w = 32'h3000_0033;
            4:       w = 32'h4000_0044;
            5:       w = 32'h5000_0055;
            6:       w = 32'h6000_0066;
            7:       w = 32'h7000_0077;
            8:       w = 32'h8000_0088;
            9:       w = 32'h9000_0099;
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mips_ctl_alu_dmem_dmem_array.sv
// Word storage: asynchronous read, rising-edge write, async reset to preload image.
// Latency: read combinational; written data visible right after the write edge.
// Backpressure: none, every write is accepted.
module mips_ctl_alu_dmem_dmem_array
    import mips_ctl_alu_dmem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[idx] = wdata;
        end
    end

    // Reset reloads the whole image, so a write edge racing reset assertion is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= preload_word(i);
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[idx];

endmodule

// File: rtl/mips_ctl_alu_dmem.sv
// ID-stage control decode, EXE-stage 32-bit ALU and MEM-stage data memory.
// Latency: decoder/ALU/read combinational; store committed on rising clk.
// Backpressure: none, all parts accept input every cycle.
module mips_ctl_alu_dmem
    import mips_ctl_alu_dmem_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    output logic        wreg,
    output logic        m2reg,
    output logic        wmem,
    output logic [1:0]  aluc,
    output logic        aluimm,
    output logic        regrt,
    input  logic [31:0] alu_a,
    input  logic [31:0] alu_b,
    input  logic [1:0]  alu_c,
    output logic [31:0] alu_r,
    output logic        alu_z,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_we,
    output logic [31:0] mem_rdata
);

    localparam int AW = $clog2(DEPTH);

    if ((DEPTH < 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 16");
    end

    logic [5:0] op;
    logic [5:0] func;
    ctl_t       ctl;

    assign op   = instr[31:26];
    assign func = instr[5:0];

    // Anything not explicitly listed decodes to an all-zero NOP.
    always_comb begin
        ctl = '0;
        case (op)
            OP_RTYPE: begin
                case (func)
                    F_ADD:   begin ctl.wreg = 1'b1; ctl.aluc = ALUC_ADD; end
                    F_SUB:   begin ctl.wreg = 1'b1; ctl.aluc = ALUC_SUB; end
                    F_AND:   begin ctl.wreg = 1'b1; ctl.aluc = ALUC_AND; end
                    F_OR:    begin ctl.wreg = 1'b1; ctl.aluc = ALUC_OR;  end
                    default: ctl = '0;
                endcase
            end
            OP_LW: begin
                ctl.wreg   = 1'b1;
                ctl.m2reg  = 1'b1;
                ctl.aluimm = 1'b1;
                ctl.regrt  = 1'b1;
            end
            OP_SW: begin
                ctl.wmem   = 1'b1;
                ctl.aluimm = 1'b1;
                ctl.regrt  = 1'b1;
            end
            OP_ADDI: begin
                ctl.wreg   = 1'b1;
                ctl.aluimm = 1'b1;
                ctl.regrt  = 1'b1;
            end
            default: ctl = '0;
        endcase
    end

    assign wreg   = ctl.wreg;
    assign m2reg  = ctl.m2reg;
    assign wmem   = ctl.wmem;
    assign aluc   = ctl.aluc;
    assign aluimm = ctl.aluimm;
    assign regrt  = ctl.regrt;

    always_comb begin
        alu_r = '0;
        case (aluc_e'(alu_c))
            ALUC_ADD: alu_r = alu_a + alu_b;
            ALUC_SUB: alu_r = alu_a - alu_b;
            ALUC_AND: alu_r = alu_a & alu_b;
            ALUC_OR:  alu_r = alu_a | alu_b;
            default:  alu_r = '0;
        endcase
    end

    assign alu_z = (alu_r == 32'h0);

    logic unused_instr_addr_bits;
    assign unused_instr_addr_bits = ^{instr[25:6], mem_addr[31:AW+2], mem_addr[1:0]};

    mips_ctl_alu_dmem_dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_dmem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .idx   (mem_addr[AW+1:2]),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_mips_ctl_alu_dmem.sv
// Table-driven plus randomized checks of decoder, ALU and data memory.
module tb_mips_ctl_alu_dmem;

    localparam int DEPTH = 64;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        wreg, m2reg, wmem, aluimm, regrt;
    logic [1:0]  aluc;
    logic [31:0] alu_a, alu_b, alu_r;
    logic [1:0]  alu_c;
    logic        alu_z;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] ref_mem [DEPTH];

    mips_ctl_alu_dmem #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .instr     (instr),
        .wreg      (wreg),
        .m2reg     (m2reg),
        .wmem      (wmem),
        .aluc      (aluc),
        .aluimm    (aluimm),
        .regrt     (regrt),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_c     (alu_c),
        .alu_r     (alu_r),
        .alu_z     (alu_z),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic ref_reset();
        logic [31:0] pre [10];
        pre = '{32'hA00000AA, 32'h10000011, 32'h20000022, 32'h30000033, 32'h40000044,
                32'h50000055, 32'h60000066, 32'h70000077, 32'h80000088, 32'h90000099};
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = (i < 10) ? pre[i] : 32'h0;
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] c);
        longint unsigned s;
        case (c)
            2'd0: s = longint'(a) + longint'(b);
            2'd1: s = longint'(a) + (64'h1_0000_0000 - longint'(b));
            2'd2: s = longint'(a & b);
            default: s = longint'(a | b);
        endcase
        return s[31:0];
    endfunction

    // Control vector order: {wreg, m2reg, wmem, aluc[1:0], aluimm, regrt}
    typedef struct {
        logic [31:0] in;
        logic [6:0]  exp;
        string       name;
    } dec_vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  c;
        logic [31:0] r;
    } alu_vec_t;

    dec_vec_t dv [11];
    alu_vec_t av [6];

    initial begin
        dv[0]  = '{32'h8C410004, 7'b1100011, "dec_lw"};
        dv[1]  = '{32'hAC410004, 7'b0010011, "dec_sw"};
        dv[2]  = '{32'h00221820, 7'b1000000, "dec_add"};
        dv[3]  = '{32'h00221822, 7'b1000100, "dec_sub"};
        dv[4]  = '{32'h00221824, 7'b1001000, "dec_and"};
        dv[5]  = '{32'h00221825, 7'b1001100, "dec_or"};
        dv[6]  = '{32'h20410004, 7'b1000011, "dec_addi"};
        dv[7]  = '{32'hFC000000, 7'b0000000, "dec_badop"};
        dv[8]  = '{32'h00000000, 7'b0000000, "dec_zero"};
        dv[9]  = '{32'h00221821, 7'b0000000, "dec_badfunc"};
        dv[10] = '{32'h10410004, 7'b0000000, "dec_beq"};

        av[0] = '{32'd5, 32'd3, 2'b00, 32'd8};
        av[1] = '{32'd5, 32'd3, 2'b01, 32'd2};
        av[2] = '{32'd5, 32'd3, 2'b10, 32'd1};
        av[3] = '{32'd5, 32'd3, 2'b11, 32'd7};
        av[4] = '{32'hFFFFFFFF, 32'd1, 2'b00, 32'h0};
        av[5] = '{32'd3, 32'd5, 2'b01, 32'hFFFFFFFE};

        rst_n = 1'b0; instr = '0; alu_a = '0; alu_b = '0; alu_c = '0;
        mem_addr = '0; mem_wdata = 32'h1234_5678; mem_we = 1'b1;
        ref_reset();

        // Writes attempted across edges while reset is held must be blocked.
        repeat (2) @(posedge clk);
        #1;
        check("reset_instr0_ctl", {25'b0, wreg, m2reg, wmem, aluc, aluimm, regrt}, 32'h0);
        check("wr_blocked_in_reset", mem_rdata, ref_mem[0]);

        @(negedge clk);
        mem_we = 1'b0;
        rst_n  = 1'b1;
        foreach (dv[i]) begin
            instr = dv[i].in;
            #1;
            check(dv[i].name, {25'b0, wreg, m2reg, wmem, aluc, aluimm, regrt}, {25'b0, dv[i].exp});
        end

        foreach (av[i]) begin
            alu_a = av[i].a; alu_b = av[i].b; alu_c = av[i].c;
            #1;
            check($sformatf("alu_vec%0d_r", i), alu_r, av[i].r);
            check($sformatf("alu_vec%0d_z", i), {31'b0, alu_z}, {31'b0, av[i].r == 32'h0});
        end

        for (int i = 0; i < 200; i++) begin
            logic [31:0] exp_r;
            alu_a = $urandom;
            alu_b = (i % 8 == 0) ? -alu_a : ((i % 8 == 1) ? alu_a : $urandom);
            alu_c = 2'($urandom_range(0, 3));
            #1;
            exp_r = alu_model(alu_a, alu_b, alu_c);
            check("alu_rand_r", alu_r, exp_r);
            check("alu_rand_z", {31'b0, alu_z}, {31'b0, exp_r == 32'h0});
        end

        // Reads after reset, including address wrap and ignored low bits.
        mem_addr = 32'h0;   #1; check("rd_0x0",   mem_rdata, 32'hA00000AA);
        mem_addr = 32'h24;  #1; check("rd_0x24",  mem_rdata, 32'h90000099);
        mem_addr = 32'h28;  #1; check("rd_0x28",  mem_rdata, 32'h0);
        mem_addr = 32'h102; #1; check("rd_0x102", mem_rdata, 32'hA00000AA);

        @(negedge clk);
        mem_addr = 32'h2C; mem_wdata = 32'hDEADBEEF; mem_we = 1'b1;
        @(posedge clk); #1;
        check("store_visible", mem_rdata, 32'hDEADBEEF);
        @(negedge clk);
        mem_we = 1'b0; mem_wdata = 32'h0BAD_0BAD;
        @(posedge clk); #1;
        check("store_held", mem_rdata, 32'hDEADBEEF);

        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        #1;
        check("reset_clears_store", mem_rdata, 32'h0);
        mem_addr = 32'h14; #1;
        check("reset_restores_w5", mem_rdata, 32'h50000055);

        // Write edge coinciding with reset assertion is lost.
        @(negedge clk);
        mem_addr = 32'h30; mem_wdata = 32'hCAFEF00D; mem_we = 1'b1;
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        check("wr_at_reset_edge_lost", mem_rdata, 32'h0);
        @(negedge clk);
        mem_we = 1'b0;
        rst_n  = 1'b1;
        #1;
        check("wr_at_reset_edge_after", mem_rdata, 32'h0);

        ref_reset();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (i == 150) begin
                rst_n = 1'b0;
                #1 rst_n = 1'b1;
                ref_reset();
            end
            mem_addr  = (i % 4 == 0) ? 32'($urandom_range(0, 11) * 4) : $urandom;
            mem_wdata = $urandom;
            mem_we    = ($urandom_range(0, 2) == 0);
            #1;
            check("mem_rand_pre", mem_rdata, ref_mem[widx(mem_addr)]);
            @(posedge clk);
            if (mem_we) ref_mem[widx(mem_addr)] = mem_wdata;
            #1;
            check("mem_rand_post", mem_rdata, ref_mem[widx(mem_addr)]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
